// File: rtl/alu_pkg.sv
// Shared ALU widths and the arbiter FSM state type, used by alu_arbiter and alu.
package alu_pkg;

    localparam int ALU_DATA_WIDTH   = 32;
    localparam int ALU_CTRL_WIDTH   = 5;
    localparam int ALU_STATUS_WIDTH = 4;
    localparam int ALU_SHAMT_WIDTH  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [NUM_REQ-1:0] rotated;
    logic [IDX_W:0]     sum;

    // Rotate so that rr_ptr lands on bit 0; the lowest set bit then wins.
    always_comb begin
        rotated     = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        grant_valid = 1'b0;
        sum         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant_valid = 1'b1;
                sum         = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            end
        end
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        grant_idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// Optional feature macro ALU_ARB_OPCOUNT_EN adds a 32-bit completed-operation counter.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = ALU_DATA_WIDTH,
    parameter int CTRL_WIDTH   = ALU_CTRL_WIDTH,
    parameter int STATUS_WIDTH = ALU_STATUS_WIDTH,
    parameter int SHAMT_WIDTH  = ALU_SHAMT_WIDTH,
    parameter int NUM_REQ      = 4,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0]   req_ctrl,
    input  logic [NUM_REQ*SHAMT_WIDTH-1:0]  req_shamt,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic [STATUS_WIDTH-1:0]         rsp_status,
    output logic [2*DATA_WIDTH-1:0]         alu_dataIn,
    output logic [CTRL_WIDTH-1:0]           alu_ctrl,
    output logic [SHAMT_WIDTH-1:0]          alu_shamt,
    input  logic [DATA_WIDTH-1:0]           alu_dataOut,
    input  logic [STATUS_WIDTH-1:0]         alu_status
`ifdef ALU_ARB_OPCOUNT_EN
    ,
    output logic [31:0]                     op_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_W = 4;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("alu_arbiter: NUM_REQ must be in 2..8");
    end
    if (ALU_LATENCY < 1 || ALU_LATENCY > 8) begin : g_bad_latency
        $error("alu_arbiter: ALU_LATENCY must be in 1..8");
    end

    arb_state_t         state;
    arb_state_t         state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [LAT_W-1:0]   lat_cnt;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               handshake;

    logic [2*DATA_WIDTH-1:0] data_arr  [NUM_REQ];
    logic [CTRL_WIDTH-1:0]   ctrl_arr  [NUM_REQ];
    logic [SHAMT_WIDTH-1:0]  shamt_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i]  = req_data[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
            ctrl_arr[i]  = req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
            shamt_arr[i] = req_shamt[i*SHAMT_WIDTH +: SHAMT_WIDTH];
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is gated by rst so a pending request cannot see an accept while reset is held.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && rst) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next           = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            owner      <= '0;
            lat_cnt    <= '0;
            alu_dataIn <= '0;
            alu_ctrl   <= '0;
            alu_shamt  <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner      <= grant_idx;
                rr_ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                lat_cnt    <= LAT_W'(ALU_LATENCY - 1);
                alu_dataIn <= data_arr[grant_idx];
                alu_ctrl   <= ctrl_arr[grant_idx];
                alu_shamt  <= shamt_arr[grant_idx];
            end else if (state == EXEC) begin
                if (lat_cnt == '0) begin
                    rsp_data   <= alu_dataOut;
                    rsp_status <= alu_status;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
        end
    end

`ifdef ALU_ARB_OPCOUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (handshake) begin
            op_count <= op_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_alu_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [255:0] req_data;
    logic [19:0]  req_ctrl, req_shamt;
    logic [31:0]  rsp_data, alu_dataOut;
    logic [3:0]   rsp_status, alu_status;
    logic [63:0]  alu_dataIn;
    logic [4:0]   alu_ctrl, alu_shamt;

    logic [3:0]   req_valid4, req_ready4, rsp_valid4, rsp_ready4;
    logic [255:0] req_data4;
    logic [19:0]  req_ctrl4, req_shamt4;
    logic [31:0]  rsp_data4, alu_dataOut4;
    logic [3:0]   rsp_status4, alu_status4;
    logic [63:0]  alu_dataIn4;
    logic [4:0]   alu_ctrl4, alu_shamt4;
`ifdef ALU_ARB_OPCOUNT_EN
    logic [31:0]  op_count, op_count4;
`endif

    int checks = 0;
    int errors = 0;
    int gorder [8];
    int gcount;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;
    vec_t vecs [8];

    // Stand-in ALU: a = dataIn low half, b = high half; status = {neg, zero, ctrl[1:0]}.
    function automatic logic [35:0] alu_fn(logic [63:0] din, logic [4:0] c, logic [4:0] sh);
        logic [31:0] a, b, r;
        a = din[31:0];
        b = din[63:32];
        case (c)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << sh;
            5'd6:    r = a >> sh;
            default: r = '0;
        endcase
        return {r[31], (r == 32'd0), c[1:0], r};
    endfunction

    assign {alu_status, alu_dataOut}   = alu_fn(alu_dataIn, alu_ctrl, alu_shamt);
    assign {alu_status4, alu_dataOut4} = alu_fn(alu_dataIn4, alu_ctrl4, alu_shamt4);

    alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(1)) dut (
`ifdef ALU_ARB_OPCOUNT_EN
        .op_count    (op_count),
`endif
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_ctrl    (req_ctrl),
        .req_shamt   (req_shamt),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .alu_dataIn  (alu_dataIn),
        .alu_ctrl    (alu_ctrl),
        .alu_shamt   (alu_shamt),
        .alu_dataOut (alu_dataOut),
        .alu_status  (alu_status)
    );

    alu_arbiter #(.NUM_REQ(4), .ALU_LATENCY(4)) u4 (
`ifdef ALU_ARB_OPCOUNT_EN
        .op_count    (op_count4),
`endif
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid4),
        .req_ready   (req_ready4),
        .req_data    (req_data4),
        .req_ctrl    (req_ctrl4),
        .req_shamt   (req_shamt4),
        .rsp_valid   (rsp_valid4),
        .rsp_ready   (rsp_ready4),
        .rsp_data    (rsp_data4),
        .rsp_status  (rsp_status4),
        .alu_dataIn  (alu_dataIn4),
        .alu_ctrl    (alu_ctrl4),
        .alu_shamt   (alu_shamt4),
        .alu_dataOut (alu_dataOut4),
        .alu_status  (alu_status4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int first_idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One isolated operation on the ALU_LATENCY=1 instance, starting from IDLE.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c, input logic [4:0] sh,
                         input logic [31:0] er, input logic [3:0] es);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        req_data[idx*64 +: 64] = {b, a};
        req_ctrl[idx*5 +: 5]   = c;
        req_shamt[idx*5 +: 5]  = sh;
        req_valid = oh;
        #1;
        chk("accept_pulse", 64'(req_ready), 64'(oh));
        step();
        req_valid = '0;
        #1;
        chk("ready_one_cycle", 64'(req_ready), 64'd0);
        chk("alu_dataIn", alu_dataIn, {b, a});
        chk("alu_ctrl", 64'(alu_ctrl), 64'(c));
        chk("alu_shamt", 64'(alu_shamt), 64'(sh));
        chk("no_early_rsp", 64'(rsp_valid), 64'd0);
        step();
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_data", 64'(rsp_data), 64'(er));
        chk("rsp_status", 64'(rsp_status), 64'(es));
        rsp_ready = oh;
        step();
        rsp_ready = '0;
        #1;
        chk("rsp_dropped", 64'(rsp_valid), 64'd0);
    endtask

    // Runs with rsp_ready held high; bits not in keep drop their request once accepted.
    task automatic collect_grants(input logic [3:0] init, input logic [3:0] keep, input int n);
        int g;
        req_valid = init;
        rsp_ready = 4'hF;
        gcount    = 0;
        for (int cyc = 0; cyc < 60 && gcount < n; cyc++) begin
            #1;
            g = -1;
            if (req_ready != 4'b0000) begin
                chk("grant_onehot", 64'($onehot(req_ready)), 64'd1);
                g = first_idx(req_ready);
                gorder[gcount] = g;
                gcount++;
            end
            step();
            if (g >= 0) req_valid[g] = keep[g];
        end
        chk("grant_count", 64'(gcount), 64'(n));
        req_valid = '0;
        repeat (4) step();
        rsp_ready = '0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_data = '0; req_ctrl = '0; req_shamt = '0; rsp_ready = '0;
        req_valid4 = '0; req_data4 = '0; req_ctrl4 = '0; req_shamt4 = '0; rsp_ready4 = '0;

        vecs[0] = '{0, 32'd5,          32'd3,   5'h02, 5'd0,  32'd1,          4'b0010};
        vecs[1] = '{1, 32'd10,         32'd3,   5'h00, 5'd0,  32'd13,         4'b0000};
        vecs[2] = '{2, 32'd3,          32'd5,   5'h01, 5'd0,  32'hFFFF_FFFE,  4'b1001};
        vecs[3] = '{3, 32'd1,          32'd0,   5'h05, 5'd31, 32'h8000_0000,  4'b1001};
        vecs[4] = '{1, 32'h0000_00F0,  32'h0F,  5'h04, 5'd0,  32'h0000_00FF,  4'b0000};
        vecs[5] = '{0, 32'd7,          32'd7,   5'h01, 5'd0,  32'd0,          4'b0101};
        vecs[6] = '{2, 32'h8000_0000,  32'd0,   5'h06, 5'd4,  32'h0800_0000,  4'b0010};
        vecs[7] = '{3, 32'hFFFF_FFFF,  32'd1,   5'h00, 5'd0,  32'd0,          4'b0100};

        step();
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_status", 64'(rsp_status), 64'd0);
        chk("rst_alu_dataIn", alu_dataIn, 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_alu_shamt", 64'(alu_shamt), 64'd0);
        req_valid = '0;
        step();
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].shamt,
                  vecs[i].res, vecs[i].st);
        end

        // Round robin from reset: all four pending
        rst = 1'b0;
        step();
        rst = 1'b1;
        collect_grants(4'hF, 4'h0, 4);
        for (int k = 0; k < 4; k++) chk("rr_order_all", 64'(gorder[k]), 64'(k));
        // Move the pointer past 1, then hold 0 and 2: pointer wraps each time
        do_op(1, 32'd2, 32'd2, 5'h00, 5'd0, 32'd4, 4'b0000);
        collect_grants(4'b0101, 4'b0101, 4);
        chk("rr_alt_0", 64'(gorder[0]), 64'd2);
        chk("rr_alt_1", 64'(gorder[1]), 64'd0);
        chk("rr_alt_2", 64'(gorder[2]), 64'd2);
        chk("rr_alt_3", 64'(gorder[3]), 64'd0);

        // Back-pressure on requester 1 with requester 3 waiting
        req_data[64 +: 64] = {32'd22, 32'd20};
        req_ctrl[5 +: 5]   = 5'h00;
        req_valid = 4'b0010;
        #1;
        chk("bp_accept1", 64'(req_ready), 64'b0010);
        step();
        req_data[192 +: 64] = {32'd2, 32'd1};
        req_ctrl[15 +: 5]   = 5'h00;
        req_valid = 4'b1000;
        #1;
        chk("bp_no_grant_exec", 64'(req_ready), 64'd0);
        step();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
            chk("bp_rsp_data", 64'(rsp_data), 64'd42);
            chk("bp_no_grant", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;
        #1;
        chk("bp_req3_after_hs", 64'(req_ready), 64'b1000);
        chk("bp_rsp_cleared", 64'(rsp_valid), 64'd0);
        step();
        req_valid = '0;
        step();
        #1;
        chk("bp_rsp3_valid", 64'(rsp_valid), 64'b1000);
        chk("bp_rsp3_data", 64'(rsp_data), 64'd3);
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;

        // ALU_LATENCY=4 instance: a|b with operands held through EXEC
        req_data4[63:0] = {32'd3, 32'd10};
        req_ctrl4[4:0]  = 5'h03;
        req_shamt4[4:0] = 5'd7;
        req_valid4 = 4'b0001;
        #1;
        chk("l4_accept", 64'(req_ready4), 64'b0001);
        step();
        req_valid4 = '0;
        req_data4  = '1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("l4_no_rsp", 64'(rsp_valid4), 64'd0);
            chk("l4_no_capture", 64'(rsp_data4), 64'd0);
            chk("l4_dataIn_stable", alu_dataIn4, {32'd3, 32'd10});
            chk("l4_ctrl_stable", 64'(alu_ctrl4), 64'd3);
            chk("l4_shamt_stable", 64'(alu_shamt4), 64'd7);
            step();
        end
        #1;
        chk("l4_rsp_valid", 64'(rsp_valid4), 64'b0001);
        chk("l4_rsp_data", 64'(rsp_data4), 64'd11);
        chk("l4_rsp_status", 64'(rsp_status4), 64'b0011);
        rsp_ready4 = 4'b0001;
        step();
        rsp_ready4 = '0;

        // Reset during EXEC drops requester 3's operation; pending requester 2 wins after
        req_data[192 +: 64] = {32'd4, 32'd4};
        req_ctrl[15 +: 5]   = 5'h00;
        req_valid = 4'b1000;
        #1;
        chk("mr_accept3", 64'(req_ready), 64'b1000);
        step();
        req_data[128 +: 64] = {32'd1, 32'd6};
        req_ctrl[10 +: 5]   = 5'h01;
        req_shamt[10 +: 5]  = 5'd0;
        req_valid = 4'b0100;
        rst = 1'b0;
        #1;
        chk("mr_req_ready", 64'(req_ready), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_rsp_data", 64'(rsp_data), 64'd0);
        chk("mr_rsp_status", 64'(rsp_status), 64'd0);
        chk("mr_alu_dataIn", alu_dataIn, 64'd0);
        chk("mr_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("mr_alu_shamt", 64'(alu_shamt), 64'd0);
        step();
        #1;
        chk("mr_rsp_valid_held", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("mr_grant2_first", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        #1;
        chk("mr_exec_no_rsp", 64'(rsp_valid), 64'd0);
        step();
        #1;
        chk("mr_rsp2_only", 64'(rsp_valid), 64'b0100);
        chk("mr_rsp2_data", 64'(rsp_data), 64'd5);
        chk("mr_rsp2_status", 64'(rsp_status), 64'b0001);
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;

`ifdef ALU_ARB_OPCOUNT_EN
        rst = 1'b0;
        #1;
        chk("oc_reset", 64'(op_count), 64'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].shamt,
                  vecs[i].res, vecs[i].st);
        end
        chk("oc_five", 64'(op_count), 64'd5);
        force dut.op_count = 32'hFFFF_FFFF;
        #1;
        release dut.op_count;
        do_op(vecs[5].idx, vecs[5].a, vecs[5].b, vecs[5].ctrl, vecs[5].shamt,
              vecs[5].res, vecs[5].st);
        chk("oc_wrap", 64'(op_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
